dio_upload: RTL and testbench

- Readback engine for the HPS ioctl upload path; the reverse of the ROM/disk download path.
- Serves HPS byte reads (e.g. saving a modified floppy image) by fetching 16-bit words from SDRAM during dioBusControl slots.
- Returns them byte-serially on ioctl_din, holding ioctl_wait until data is ready.
- Drives an SDRAM request that the top-level muxes in place of the download request whenever upload_cycle is high.

---
 rtl/dio_upload.sv | 139 +++++++++++++
 tb/tb_dio_upload.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dio_upload.sv
// HPS upload readback engine: fetches 16-bit SDRAM words during DIO slots and
// returns them byte-serially on ioctl_din, with a one-word cache for the odd/even pair.
module dio_upload #(
  parameter logic [20:0] BASE1        = 21'h080000,
  parameter logic [20:0] BASE2        = 21'h100000,
  parameter logic [3:0]  SDRAM_PREFIX = 4'b0001
) (
  input  logic        clk_sys,
  input  logic        n_reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  input  logic        dioBusControl,
  input  logic [15:0] sdram_dout,
  output logic [24:0] sdram_addr,
  output logic        sdram_oe,
  output logic        upload_cycle
);

  typedef enum logic [2:0] {IDLE, ARM, SYNC, SLOT, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_tag;
  logic [7:0]  r_tagIndex;
  logic        r_valid;
  logic        r_lsb;
  logic [15:0] r_word;
  logic [7:0]  r_din;
  logic        r_wait;
  logic [24:0] r_sdramAddr;

  logic        w_request;
  logic        w_hit;
  logic        w_miss;
  logic        w_capture;
  logic        w_finish;
  logic        w_oe;
  logic [20:0] w_base;
  logic [20:0] w_wordAddr;

  // The cache is keyed by both word address and region, so a region switch never hits.
  assign w_request = ioctl_upload && ioctl_rd && (r_state == IDLE);
  assign w_hit     = w_request && r_valid && (r_tag == ioctl_addr[24:1])
                     && (r_tagIndex == ioctl_index);
  assign w_miss    = w_request && !w_hit;

  always_comb begin
    w_base = BASE2;
    case (ioctl_index)
      8'd0:    w_base = 21'h000000;
      8'd1:    w_base = BASE1;
      default: w_base = BASE2;
    endcase
  end

  assign w_wordAddr = w_base + ioctl_addr[21:1];

  always_ff @(posedge clk_sys) begin
    if (!n_reset || !ioctl_upload) r_state <= IDLE;
    else                           r_state <= w_next;
  end

  // ARM waits out any slot already in progress so a fetch always sees a full slot.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_finish  = 1'b0;
    w_oe      = 1'b0;
    case (r_state)
      IDLE: if (w_miss) w_next = ARM;
      ARM:  if (!dioBusControl) w_next = SYNC;
      SYNC: begin
        w_oe = dioBusControl;
        if (dioBusControl) w_next = SLOT;
      end
      SLOT: begin
        w_oe = dioBusControl;
        if (!dioBusControl) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_finish = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!n_reset) begin
      r_din       <= 8'h00;
      r_wait      <= 1'b0;
      r_valid     <= 1'b0;
      r_word      <= 16'h0000;
      r_tag       <= 24'h000000;
      r_tagIndex  <= 8'h00;
      r_lsb       <= 1'b0;
      r_sdramAddr <= {SDRAM_PREFIX, 21'h000000};
    end else if (!ioctl_upload) begin
      r_wait  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (ioctl_index != r_tagIndex) r_valid <= 1'b0;
      if (w_request) begin
        r_tag       <= ioctl_addr[24:1];
        r_tagIndex  <= ioctl_index;
        r_lsb       <= ioctl_addr[0];
        r_sdramAddr <= {SDRAM_PREFIX, w_wordAddr};
      end
      if (w_hit) r_din <= ioctl_addr[0] ? r_word[7:0] : r_word[15:8];
      if (w_miss) begin
        r_wait  <= 1'b1;
        r_valid <= 1'b0;
      end
      if (w_capture) begin
        r_word  <= sdram_dout;
        r_valid <= 1'b1;
      end
      if (w_finish) begin
        r_din  <= r_lsb ? r_word[7:0] : r_word[15:8];
        r_wait <= 1'b0;
      end
    end
  end

  // Outputs are forced to their reset values combinationally so a reset mid-fetch takes effect at once.
  assign ioctl_din    = n_reset ? r_din : 8'h00;
  assign ioctl_wait   = r_wait && n_reset;
  assign sdram_addr   = n_reset ? r_sdramAddr : {SDRAM_PREFIX, 21'h000000};
  assign sdram_oe     = w_oe && ioctl_upload && n_reset;
  assign upload_cycle = ioctl_upload && dioBusControl;

endmodule

// File: tb/tb_dio_upload.sv
// Self-checking bench for dio_upload: SDRAM responder, DIO slot generator,
// and a word-level cache/address model driving randomized and directed reads.
module tb_dio_upload;

  localparam int PERIOD = 8;
  localparam int HIGH   = 3;

  logic        clk_sys = 1'b0;
  logic        n_reset = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'h0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        dioBusControl = 1'b0;
  logic [15:0] sdram_dout = 16'h0000;
  logic [24:0] sdram_addr;
  logic        sdram_oe;
  logic        upload_cycle;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [logic [24:0]];
  bit          modelValid = 1'b0;
  logic [23:0] modelTag = 24'h0;
  logic [7:0]  modelIndex = 8'h00;

  int          oeCycles = 0;
  int          oeSlots = 0;
  int          dioRises = 0;
  int          oeRiseAt = -1;
  logic [24:0] lastOeAddr = 25'h0;
  logic        prevOe = 1'b0;
  logic        prevDio = 1'b0;

  dio_upload dut (
    .clk_sys(clk_sys), .n_reset(n_reset), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .dioBusControl(dioBusControl),
    .sdram_dout(sdram_dout), .sdram_addr(sdram_addr), .sdram_oe(sdram_oe),
    .upload_cycle(upload_cycle)
  );

  always #5 clk_sys = ~clk_sys;

  // DIO slot: low for PERIOD-HIGH cycles, high for HIGH cycles, changed shortly after posedge.
  always begin
    for (int i = 0; i < PERIOD; i++) begin
      @(posedge clk_sys);
      #2;
      dioBusControl = (i >= PERIOD - HIGH);
    end
  end

  function automatic logic [15:0] memRead(input logic [24:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  always @(posedge clk_sys) begin
    if (sdram_oe) sdram_dout <= memRead(sdram_addr);
  end

  // Bus monitor, sampled mid low phase after any bench drive has settled.
  always begin
    @(negedge clk_sys);
    #3;
    checks++;
    if (sdram_oe && !dioBusControl) begin
      errors++;
      $display("[TB] FAIL oe_outside_slot: got oe=%b dio=%b required oe=0", sdram_oe, dioBusControl);
    end
    checks++;
    if (upload_cycle !== (ioctl_upload && dioBusControl)) begin
      errors++;
      $display("[TB] FAIL upload_cycle: got %b required %b", upload_cycle, ioctl_upload && dioBusControl);
    end
    if (dioBusControl && !prevDio) dioRises++;
    if (sdram_oe) begin
      oeCycles++;
      lastOeAddr = sdram_addr;
      if (!prevOe) begin
        oeSlots++;
        oeRiseAt = dioRises;
      end
    end
    prevOe  = sdram_oe;
    prevDio = dioBusControl;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [24:0] expAddr(input logic [7:0] idx, input logic [24:0] a);
    int unsigned base;
    int unsigned w;
    base = (idx == 8'd0) ? 32'h0 : (idx == 8'd1) ? 32'h80000 : 32'h100000;
    w = (base + ((32'(a) >> 1) % 32'h200000)) % 32'h200000;
    return 25'(32'h200000 + w);
  endfunction

  task automatic clearMonitor();
    oeCycles = 0;
    oeSlots  = 0;
    dioRises = 0;
    oeRiseAt = -1;
  endtask

  task automatic doRead(input logic [7:0] idx, input logic [24:0] a, input bit spam);
    bit          expHit;
    logic [24:0] ea;
    logic [15:0] w;
    logic [7:0]  expByte;
    int          waitCycles;
    ea      = expAddr(idx, a);
    w       = memRead(ea);
    expByte = a[0] ? w[7:0] : w[15:8];
    expHit  = modelValid && (modelTag == a[24:1]) && (modelIndex == idx);
    @(negedge clk_sys);
    clearMonitor();
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_rd    = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    checks++;
    if (ioctl_wait !== (expHit ? 1'b0 : 1'b1)) begin
      errors++;
      $display("[TB] FAIL wait_start addr=%h: got %b required %b", a, ioctl_wait, !expHit);
    end
    if (expHit) begin
      checks++;
      if (ioctl_din !== expByte) begin
        errors++;
        $display("[TB] FAIL hit_data addr=%h: got %h required %h", a, ioctl_din, expByte);
      end
      @(negedge clk_sys);
      checks++;
      if (oeSlots !== 0 || ioctl_wait !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hit_no_fetch addr=%h: got slots=%0d wait=%b required 0/0", a, oeSlots, ioctl_wait);
      end
    end else begin
      waitCycles = 0;
      while (ioctl_wait === 1'b1 && waitCycles < 40) begin
        waitCycles++;
        if (spam) begin
          ioctl_rd   = 1'b1;
          ioctl_addr = 25'($urandom);
        end
        @(negedge clk_sys);
      end
      ioctl_rd   = 1'b0;
      ioctl_addr = a;
      checks++;
      if (waitCycles > 2 * PERIOD + 2) begin
        errors++;
        $display("[TB] FAIL miss_latency addr=%h: got %0d cycles required <= %0d", a, waitCycles, 2 * PERIOD + 2);
      end
      checks++;
      if (ioctl_din !== expByte) begin
        errors++;
        $display("[TB] FAIL miss_data addr=%h: got %h required %h", a, ioctl_din, expByte);
      end
      checks++;
      if (oeSlots !== 1) begin
        errors++;
        $display("[TB] FAIL oe_slots addr=%h: got %0d required 1", a, oeSlots);
      end
      checks++;
      if (lastOeAddr !== ea) begin
        errors++;
        $display("[TB] FAIL sdram_addr addr=%h: got %h required %h", a, lastOeAddr, ea);
      end
      checks++;
      if (oeRiseAt < 1 || oeRiseAt > 2) begin
        errors++;
        $display("[TB] FAIL slot_choice addr=%h: got slot %0d required 1..2", a, oeRiseAt);
      end
      modelValid = 1'b1;
      modelTag   = a[24:1];
      modelIndex = idx;
    end
  endtask

  task automatic test_reset();
    n_reset      = 1'b0;
    ioctl_upload = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (ioctl_wait !== 1'b0 || sdram_oe !== 1'b0 || ioctl_din !== 8'h00 || sdram_addr !== 25'h0200000) begin
      errors++;
      $display("[TB] FAIL reset_state: got wait=%b oe=%b din=%h addr=%h required 0/0/00/0200000",
               ioctl_wait, sdram_oe, ioctl_din, sdram_addr);
    end
    n_reset = 1'b1;
    clearMonitor();
    repeat (100) @(negedge clk_sys);
    checks++;
    if (oeCycles !== 0 || ioctl_wait !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_quiet: got oe cycles=%0d wait=%b required 0/0", oeCycles, ioctl_wait);
    end
    modelValid = 1'b0;
  endtask

  task automatic test_index1();
    mem[25'h0280000] = 16'hA55A;
    doRead(8'd1, 25'h0000000, 1'b0);
    doRead(8'd1, 25'h0000001, 1'b0);
  endtask

  task automatic test_index2_wrap();
    mem[25'h0300003] = 16'h1234;
    doRead(8'd2, 25'h0000006, 1'b0);
    doRead(8'd2, 25'h03FFFFE, 1'b0);
    doRead(8'd7, 25'h0000006, 1'b0);
  endtask

  task automatic test_rd_during_slot();
    int n;
    n = 0;
    while (dioBusControl !== 1'b0 && n < 50) begin @(negedge clk_sys); n++; end
    while (dioBusControl !== 1'b1 && n < 50) begin @(negedge clk_sys); n++; end
    doRead(8'd1, 25'h0000040, 1'b0);
    checks++;
    if (oeRiseAt !== 1) begin
      errors++;
      $display("[TB] FAIL mid_slot_join: got slot %0d required 1", oeRiseAt);
    end
  endtask

  task automatic test_abort();
    logic [7:0] savedDin;
    int         n;
    savedDin = ioctl_din;
    @(negedge clk_sys);
    ioctl_index = 8'd1;
    ioctl_addr  = 25'h0000080;
    ioctl_rd    = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    n = 0;
    while (sdram_oe !== 1'b1 && n < 40) begin @(negedge clk_sys); n++; end
    checks++;
    if (sdram_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_reach_slot: got oe=%b required 1", sdram_oe);
    end
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    modelValid   = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (ioctl_wait !== 1'b0 || sdram_oe !== 1'b0 || ioctl_din !== savedDin) begin
      errors++;
      $display("[TB] FAIL abort: got wait=%b oe=%b din=%h required 0/0/%h", ioctl_wait, sdram_oe, ioctl_din, savedDin);
    end
    clearMonitor();
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    repeat (2 * PERIOD) @(negedge clk_sys);
    checks++;
    if (ioctl_wait !== 1'b0 || oeCycles !== 0) begin
      errors++;
      $display("[TB] FAIL rd_without_upload: got wait=%b oe cycles=%0d required 0/0", ioctl_wait, oeCycles);
    end
    ioctl_upload = 1'b1;
    doRead(8'd1, 25'h0000080, 1'b0);
  endtask

  task automatic test_back_to_back();
    mem[25'h020007F] = 16'hBEEF;
    doRead(8'd0, 25'h00000FE, 1'b1);
    doRead(8'd0, 25'h00000FF, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0]  idx;
    logic [24:0] a;
    int          r;
    idx = 8'd1;
    a   = 25'h0001000;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        idx = 8'($urandom_range(0, 3));
        if (idx == 8'd3) idx = 8'($urandom_range(3, 255));
      end
      r = $urandom_range(0, 9);
      if (r < 5) a = a ^ 25'h1;
      else if (r < 7) a = {a[24:1], 1'b0};
      else a = 25'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        modelValid   = 1'b0;
        repeat (2) @(negedge clk_sys);
        ioctl_upload = 1'b1;
      end
      doRead(idx, a, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    $display("[TB] dio_upload bench start");
    test_reset();
    test_index1();
    test_index2_wrap();
    test_rd_during_slot();
    test_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk_sys);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
